// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the bit-serial ALU sequencer and its 1-bit slice:
//   opcode encodings, FSM state encoding and a small opcode helper.
// -----------------------------------------------------------------------------
package alu_pkg;

  // Opcode encodings carried on SELECT. 011, 101 and 111 are illegal.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b110;

  // Sequencer states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // True for the opcodes that use the carry chain (ADD/SUB).
  function automatic logic is_arith(input logic [2:0] sel);
    return (sel == ALU_ADD) || (sel == ALU_SUB);
  endfunction

endpackage : alu_pkg

// File: rtl/alu_serial_slice.sv
// -----------------------------------------------------------------------------
// alu_serial_slice
//   Purely combinational 1-bit ALU slice. Handles the B inversion for SUB, so
//   the caller only has to preset the carry-in to 1 for subtraction.
//
//   Ports:
//     a, b  : operand bits for the current bit position
//     cin   : carry into this bit position
//     sel   : opcode (alu_pkg encodings)
//     res   : result bit (0 for illegal opcodes)
//     cout  : carry out of this bit position (0 for logic/illegal opcodes)
// -----------------------------------------------------------------------------
module alu_serial_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [2:0] sel,
  output logic       res,
  output logic       cout
);

  logic b_eff;

  // NOTE: every output of a combinational block gets a default before the
  // case statement so no path leaves it unassigned (which would infer a latch).
  always_comb begin
    b_eff = (sel == ALU_SUB) ? ~b : b;
    res   = 1'b0;
    cout  = 1'b0;
    case (sel)
      ALU_ADD, ALU_SUB: begin
        res  = a ^ b_eff ^ cin;
        cout = (a & b_eff) | (a & cin) | (b_eff & cin);
      end
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      ALU_XOR: res = a ^ b;
      default: begin
        res  = 1'b0;
        cout = 1'b0;
      end
    endcase
  end

endmodule : alu_serial_slice

// File: rtl/alu_serial_ctrl.sv
// -----------------------------------------------------------------------------
// alu_serial_ctrl
//   Bit-serial WIDTH-bit ALU sequencer. On an accepted START it latches the
//   operands and opcode, then pushes one bit pair per clock (LSB first)
//   through alu_serial_slice with a registered carry. After WIDTH bits it
//   registers RESULT and the flags and pulses DONE for one cycle.
//
//   Ports:
//     CLK        : clock, rising edge
//     RST_N      : asynchronous active-low reset
//     START      : request, accepted only while BUSY=0
//     SELECT     : opcode (ADD 000, SUB 001, AND 010, OR 100, XOR 110)
//     OP_A, OP_B : operands, sampled only on the accepting edge
//     BUSY       : high while bits are being processed
//     DONE       : one-cycle pulse, results valid
//     RESULT     : result word, held until the next completed operation
//     CARRY_OUT  : final carry (SUB: 1 = no borrow), 0 for logic ops
//     ZERO_FLAG  : RESULT == 0
//     OVERFLOW   : signed overflow for ADD/SUB, 0 otherwise
// -----------------------------------------------------------------------------
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [2:0]       SELECT,
  input  logic [WIDTH-1:0] OP_A,
  input  logic [WIDTH-1:0] OP_B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             CARRY_OUT,
  output logic             ZERO_FLAG,
  output logic             OVERFLOW
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sh_a_q, sh_a_d;
  logic [WIDTH-1:0]   sh_b_q, sh_b_d;
  logic [WIDTH-1:0]   sh_r_q, sh_r_d;
  logic [2:0]         op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               zacc_q, zacc_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q, cout_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;

  logic               slice_res;
  logic               slice_cout;
  logic               last_bit;

  alu_serial_slice u_slice (
    .a    (sh_a_q[0]),
    .b    (sh_b_q[0]),
    .cin  (carry_q),
    .sel  (op_q),
    .res  (slice_res),
    .cout (slice_cout)
  );

  assign last_bit = (cnt_q == LAST_BIT);

  always_comb begin
    state_d  = state_q;
    sh_a_d   = sh_a_q;
    sh_b_d   = sh_b_q;
    sh_r_d   = sh_r_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    zacc_d   = zacc_q;
    busy_d   = busy_q;
    done_d   = 1'b0;          // DONE is a single-cycle pulse by default
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_RUN;
          busy_d  = 1'b1;
          sh_a_d  = OP_A;
          sh_b_d  = OP_B;
          op_d    = SELECT;
          cnt_d   = '0;
          // SUB is A + ~B + 1: the +1 enters as the initial carry.
          carry_d = (SELECT == ALU_SUB);
          zacc_d  = 1'b0;
        end
      end

      ST_RUN: begin
        sh_r_d  = {slice_res, sh_r_q[WIDTH-1:1]};
        sh_a_d  = sh_a_q >> 1;
        sh_b_d  = sh_b_q >> 1;
        carry_d = slice_cout;
        zacc_d  = zacc_q | slice_res;
        cnt_d   = cnt_q + 1'b1;
        if (last_bit) begin
          state_d  = ST_IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          // Final bit is still in flight, so take it straight from the slice.
          result_d = {slice_res, sh_r_q[WIDTH-1:1]};
          cout_d   = slice_cout;
          zero_d   = ~(zacc_q | slice_res);
          // carry_q is the carry into the MSB, slice_cout the carry out of it.
          ovf_d    = is_arith(op_q) & (carry_q ^ slice_cout);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values computed above regardless of statement order.
  // The operand/result shift registers are reset as well: RESULT must read 0
  // after reset and the datapath is small enough that a clean state is cheap.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      sh_a_q   <= '0;
      sh_b_q   <= '0;
      sh_r_q   <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      zacc_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_a_q   <= sh_a_d;
      sh_b_q   <= sh_b_d;
      sh_r_q   <= sh_r_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      zacc_q   <= zacc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign RESULT    = result_q;
  assign CARRY_OUT = cout_q;
  assign ZERO_FLAG = zero_q;
  assign OVERFLOW  = ovf_q;

endmodule : alu_serial_ctrl

// File: tb/tb_alu_serial_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_serial_ctrl
//   Self-checking bench for alu_serial_ctrl at WIDTH=8. Directed vectors carry
//   hand-derived expectations; random vectors are scored against an arithmetic
//   reference model. Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_serial_ctrl;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         z;
    logic         o;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   sel;
    exp_t         e;
  } vec_t;

  logic         CLK;
  logic         RST_N;
  logic         START;
  logic [2:0]   SELECT;
  logic [W-1:0] OP_A;
  logic [W-1:0] OP_B;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] RESULT;
  logic         CARRY_OUT;
  logic         ZERO_FLAG;
  logic         OVERFLOW;

  int n_checks = 0;
  int n_errors = 0;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .START     (START),
    .SELECT    (SELECT),
    .OP_A      (OP_A),
    .OP_B      (OP_B),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .RESULT    (RESULT),
    .CARRY_OUT (CARRY_OUT),
    .ZERO_FLAG (ZERO_FLAG),
    .OVERFLOW  (OVERFLOW)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain word-level arithmetic.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] sel);
    exp_t       e;
    logic [W:0] wide;
    e = '0;
    case (sel)
      3'b000: begin
        wide = {1'b0, a} + {1'b0, b};
        e.r  = wide[W-1:0];
        e.c  = wide[W];
        e.o  = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
      end
      3'b001: begin
        wide = {1'b0, a} - {1'b0, b};
        e.r  = wide[W-1:0];
        e.c  = (a >= b);
        e.o  = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
      end
      3'b010:  e.r = a & b;
      3'b100:  e.r = a | b;
      3'b110:  e.r = a ^ b;
      default: e.r = '0;
    endcase
    e.z = (e.r == '0);
    return e;
  endfunction

  // Called at a falling edge. Presents one request, checks BUSY/DONE on every
  // cycle and the results in the DONE cycle; returns in the DONE cycle so the
  // caller may issue the next START there. restart_at >= 0 re-asserts START
  // (with different operands) in that RUN cycle; it must be ignored.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] sel, input exp_t e, input int restart_at);
    START  = 1'b1;
    OP_A   = a;
    OP_B   = b;
    SELECT = sel;
    for (int k = 0; k < W; k++) begin
      @(negedge CLK);
      check($sformatf("%s busy_done[%0d]", tag, k), {62'd0, BUSY, DONE}, 64'd2);
      if (restart_at >= 0 && k == restart_at) begin
        START  = 1'b1;
        OP_A   = 8'h10;
        OP_B   = 8'h10;
        SELECT = 3'b000;
      end else begin
        START  = 1'b0;
        OP_A   = W'($urandom);
        OP_B   = W'($urandom);
        SELECT = 3'($urandom);
      end
    end
    @(negedge CLK);
    START = 1'b0;
    check($sformatf("%s done", tag), {62'd0, BUSY, DONE}, 64'd1);
    check($sformatf("%s result", tag), 64'(RESULT), 64'(e.r));
    check($sformatf("%s carry", tag), 64'(CARRY_OUT), 64'(e.c));
    check($sformatf("%s zero", tag), 64'(ZERO_FLAG), 64'(e.z));
    check($sformatf("%s ovf", tag), 64'(OVERFLOW), 64'(e.o));
  endtask

  task automatic expect_idle(input string tag);
    @(negedge CLK);
    check($sformatf("%s idle", tag), {62'd0, BUSY, DONE}, 64'd0);
  endtask

  vec_t directed [9];

  initial begin
    logic [W-1:0] corners [4];
    logic [W-1:0] ra, rb;
    logic [2:0]   rs;
    int           seen;

    corners[0] = 8'h00; corners[1] = 8'hFF; corners[2] = 8'h7F; corners[3] = 8'h80;

    //                  a      b      sel     r      c     z     o
    directed[0] = '{8'hFF, 8'h01, 3'b000, '{8'h00, 1'b1, 1'b1, 1'b0}};
    directed[1] = '{8'h05, 8'h07, 3'b001, '{8'hFE, 1'b0, 1'b0, 1'b0}};
    directed[2] = '{8'h80, 8'h01, 3'b001, '{8'h7F, 1'b1, 1'b0, 1'b1}};
    directed[3] = '{8'h7F, 8'h01, 3'b000, '{8'h80, 1'b0, 1'b0, 1'b1}};
    directed[4] = '{8'hF0, 8'h3C, 3'b010, '{8'h30, 1'b0, 1'b0, 1'b0}};
    directed[5] = '{8'hF0, 8'h0F, 3'b100, '{8'hFF, 1'b0, 1'b0, 1'b0}};
    directed[6] = '{8'hAA, 8'hAA, 3'b110, '{8'h00, 1'b0, 1'b1, 1'b0}};
    directed[7] = '{8'h5A, 8'hC3, 3'b111, '{8'h00, 1'b0, 1'b1, 1'b0}};
    directed[8] = '{8'h33, 8'h33, 3'b001, '{8'h00, 1'b1, 1'b1, 1'b0}};

    RST_N  = 1'b0;
    START  = 1'b0;
    SELECT = 3'b000;
    OP_A   = '0;
    OP_B   = '0;

    #12;
    check("reset outputs", {53'd0, BUSY, DONE, RESULT, CARRY_OUT, ZERO_FLAG, OVERFLOW}, 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check("post reset outputs", {53'd0, BUSY, DONE, RESULT, CARRY_OUT, ZERO_FLAG, OVERFLOW}, 64'd0);

    // Directed table; odd entries are issued in the previous DONE cycle.
    for (int i = 0; i < 9; i++) begin
      run_op($sformatf("dir%0d", i), directed[i].a, directed[i].b, directed[i].sel,
             directed[i].e, -1);
      if (i % 2 == 1 || i == 8) expect_idle($sformatf("dir%0d", i));
    end

    // START during RUN is ignored: 0x01+0x01 must complete as 0x02.
    run_op("ignore_start", 8'h01, 8'h01, 3'b000, '{8'h02, 1'b0, 1'b0, 1'b0}, 2);
    expect_idle("ignore_start");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 60; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : W'($urandom);
      rs = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) rs = 3'($urandom_range(0, 3) * 2);
      run_op($sformatf("rnd%0d", i), ra, rb, rs, model(ra, rb, rs), -1);
      if ($urandom_range(0, 2) != 0) expect_idle($sformatf("rnd%0d", i));
    end
    expect_idle("rnd_end");

    // Leave a nonzero result, then abort a run with reset at cycle 4.
    run_op("pre_abort", 8'hF0, 8'h3C, 3'b010, '{8'h30, 1'b0, 1'b0, 1'b0}, -1);
    START  = 1'b1;
    OP_A   = 8'h12;
    OP_B   = 8'h34;
    SELECT = 3'b000;
    @(negedge CLK);
    START = 1'b0;
    repeat (3) @(negedge CLK);
    check("abort busy before reset", 64'(BUSY), 64'd1);
    RST_N = 1'b0;
    #1;
    check("abort async reset", {53'd0, BUSY, DONE, RESULT, CARRY_OUT, ZERO_FLAG, OVERFLOW}, 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    seen = 0;
    for (int k = 0; k < 2 * W; k++) begin
      @(negedge CLK);
      if (DONE || BUSY) seen++;
    end
    check("abort no done", 64'(seen), 64'd0);

    // Operation after the abort completes normally.
    run_op("recover", 8'h7F, 8'h7F, 3'b000, '{8'hFE, 1'b0, 1'b0, 1'b1}, -1);
    expect_idle("recover");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_alu_serial_ctrl
